// File: rtl/loader_pkg.sv
// Shared types and default sizes for the instruction-memory loader.
package loader_pkg;

  localparam int IW_DEF         = 9;
  localparam int AW_DEF         = 8;
  localparam int DEPTH_DEF      = 256;
  localparam int MAX_CYCLES_DEF = 4096;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    FINISH
  } ldr_state_t;

endpackage

// File: rtl/ldr_cycle_ctr.sv
// Saturating RUN-phase cycle counter; term flags the MAX-th enabled cycle.
module ldr_cycle_ctr #(
  parameter int MAX = 4096,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic term
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != W'(MAX))) begin
      cnt <= cnt + 1'b1;
    end
  end

  // cnt is 0 in the first enabled cycle, so MAX-1 marks the MAX-th one
  assign term = en && (cnt == W'(MAX - 1));

endmodule

// File: rtl/imem_loader.sv
// Streams host machine code into instruction memory, runs the core, reports status.
// Optional RUN-phase timeout is enabled by defining CYCLE_TIMEOUT_EN.
module imem_loader
  import loader_pkg::*;
#(
  parameter int IW         = IW_DEF,
  parameter int AW         = AW_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int MAX_CYCLES = MAX_CYCLES_DEF
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          start,
  input  logic          in_valid,
  input  logic [IW-1:0] in_data,
  input  logic          in_last,
  output logic          in_ready,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [IW-1:0] wr_data,
  output logic          core_reset,
  input  logic          core_done,
  output logic          load_done,
  output logic [AW:0]   word_count,
  output logic          err_overflow,
  output logic          err_timeout
);

  ldr_state_t state, state_nxt;

  logic [AW-1:0] addr_cnt;
  logic          stop_accept;
  logic          wr_last_q;
  logic          wr_ovf_q;
  logic          accept;
  logic          start_ok;
  logic          at_end;
  logic          timeout_hit;

  assign start_ok = start && ((state == IDLE) || (state == FINISH));
  assign accept   = in_valid && in_ready;
  assign at_end   = (addr_cnt == AW'(DEPTH - 1));

`ifdef CYCLE_TIMEOUT_EN
  logic ctr_term;

  ldr_cycle_ctr #(
    .MAX(MAX_CYCLES)
  ) u_cycle_ctr (
    .clk (Clk),
    .rst (Reset),
    .clr (state != RUN),
    .en  (state == RUN),
    .term(ctr_term)
  );

  // core_done in the terminal cycle takes priority over the timeout
  assign timeout_hit = ctr_term && !core_done;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      err_timeout <= 1'b0;
    end else if (start_ok) begin
      err_timeout <= 1'b0;
    end else if (timeout_hit) begin
      err_timeout <= 1'b1;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg  = (MAX_CYCLES > 0);
  assign timeout_hit = 1'b0;
  assign err_timeout = 1'b0;
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (start_ok) state_nxt = LOAD;
      LOAD: begin
        if (wr_en && wr_last_q)     state_nxt = RUN;
        else if (wr_en && wr_ovf_q) state_nxt = FINISH;
      end
      RUN:    if (core_done || timeout_hit) state_nxt = FINISH;
      FINISH: if (start_ok) state_nxt = LOAD;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready   = (state == LOAD) && !stop_accept;
    core_reset = (state != RUN);
    load_done  = (state == FINISH);
  end

  // Accepted words are registered and written one cycle later; acceptance
  // stops after the last word or the word at the top address.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      addr_cnt     <= '0;
      word_count   <= '0;
      stop_accept  <= 1'b0;
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      wr_last_q    <= 1'b0;
      wr_ovf_q     <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      wr_en <= accept;
      if (start_ok) begin
        addr_cnt     <= '0;
        word_count   <= '0;
        stop_accept  <= 1'b0;
        err_overflow <= 1'b0;
      end else begin
        if (accept) begin
          wr_addr   <= addr_cnt;
          wr_data   <= in_data;
          wr_last_q <= in_last;
          wr_ovf_q  <= !in_last && at_end;
          if (in_last || at_end) stop_accept <= 1'b1;
          if (!at_end) addr_cnt <= addr_cnt + 1'b1;
        end
        if (wr_en) begin
          word_count <= word_count + 1'b1;
          if (wr_ovf_q) err_overflow <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader (DEPTH=4, MAX_CYCLES=10).
module tb_imem_loader;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       start;
  logic       in_valid;
  logic [8:0] in_data;
  logic       in_last;
  logic       in_ready;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [8:0] wr_data;
  logic       core_reset;
  logic       core_done;
  logic       load_done;
  logic [8:0] word_count;
  logic       err_overflow;
  logic       err_timeout;

  int total = 0;
  int bad   = 0;

  imem_loader #(
    .IW(9), .AW(8), .DEPTH(4), .MAX_CYCLES(10)
  ) dut (
    .Clk(Clk), .Reset(Reset), .start(start),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .core_reset(core_reset), .core_done(core_done), .load_done(load_done),
    .word_count(word_count), .err_overflow(err_overflow), .err_timeout(err_timeout)
  );

  always #5 Clk = ~Clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic v, input logic [8:0] d, input logic l);
    start    = s;
    in_valid = v;
    in_data  = d;
    in_last  = l;
  endtask

  task automatic pulseStart();
    applyStimulus(1'b1, 1'b0, 9'h0, 1'b0);
    tick();
    start = 1'b0;
  endtask

  logic [8:0] basic_words [3] = '{9'h1A3, 9'h055, 9'h1FF};
  logic [8:0] gap_words   [3] = '{9'h011, 9'h122, 9'h033};

  initial begin
    Reset = 1'b1;
    core_done = 1'b0;
    applyStimulus(1'b0, 1'b0, 9'h0, 1'b0);
    repeat (2) tick();
    checkOutput("rst_core_reset", core_reset, 1);
    checkOutput("rst_in_ready", in_ready, 0);
    checkOutput("rst_wr_en", wr_en, 0);
    checkOutput("rst_word_count", word_count, 0);
    checkOutput("rst_load_done", load_done, 0);
    checkOutput("rst_errs", {err_overflow, err_timeout}, 0);
    Reset = 1'b0;
    tick();
    checkOutput("idle_in_ready", in_ready, 0);

    // basic load of three words, valid held high
    pulseStart();
    checkOutput("basic_ready", in_ready, 1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, basic_words[i], i == 2);
      tick();
      checkOutput("basic_wr_en", wr_en, 1);
      checkOutput("basic_wr_addr", wr_addr, i);
      checkOutput("basic_wr_data", wr_data, basic_words[i]);
      checkOutput("basic_core_reset_load", core_reset, 1);
    end
    checkOutput("basic_ready_drop", in_ready, 0);
    applyStimulus(1'b0, 1'b0, 9'h0, 1'b0);
    core_done = 1'b1;
    tick();
    checkOutput("basic_run_core_reset", core_reset, 0);
    checkOutput("basic_run_wr_en", wr_en, 0);
    checkOutput("basic_word_count", word_count, 3);
    tick();
    core_done = 1'b0;
    checkOutput("basic_load_done", load_done, 1);
    checkOutput("basic_fin_core_reset", core_reset, 1);
    checkOutput("basic_fin_count", word_count, 3);

    // reload from FINISH with gaps; a start pulse during LOAD is ignored
    pulseStart();
    checkOutput("gap_count_cleared", word_count, 0);
    checkOutput("gap_load_done_low", load_done, 0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(i == 1, (i % 2) == 0, gap_words[i / 2], i == 4);
      tick();
      checkOutput("gap_wr_en", wr_en, (i % 2) == 0);
      if ((i % 2) == 0) begin
        checkOutput("gap_wr_addr", wr_addr, i / 2);
        checkOutput("gap_wr_data", wr_data, gap_words[i / 2]);
      end
    end
    applyStimulus(1'b0, 1'b0, 9'h0, 1'b0);
    tick();
    checkOutput("gap_run_core_reset", core_reset, 0);
    // start and in_valid during RUN have no effect
    applyStimulus(1'b1, 1'b1, 9'h1EE, 1'b1);
    checkOutput("run_in_ready", in_ready, 0);
    tick();
    checkOutput("run_ign_wr_en", wr_en, 0);
    checkOutput("run_ign_core_reset", core_reset, 0);
    checkOutput("run_ign_count", word_count, 3);
    applyStimulus(1'b0, 1'b0, 9'h0, 1'b0);
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    checkOutput("gap_load_done", load_done, 1);

    // overflow: four words, never last
    pulseStart();
    for (int i = 0; i < 4; i++) begin
      checkOutput("ovf_ready", in_ready, 1);
      applyStimulus(1'b0, 1'b1, 9'h100 + 9'(i), 1'b0);
      tick();
      checkOutput("ovf_wr_en", wr_en, 1);
      checkOutput("ovf_wr_addr", wr_addr, i);
      checkOutput("ovf_wr_data", wr_data, 9'h100 + 9'(i));
      checkOutput("ovf_core_reset", core_reset, 1);
    end
    checkOutput("ovf_ready_drop", in_ready, 0);
    applyStimulus(1'b0, 1'b1, 9'h0AA, 1'b1);
    tick();
    checkOutput("ovf_no_extra_wr", wr_en, 0);
    checkOutput("ovf_flag", err_overflow, 1);
    checkOutput("ovf_load_done", load_done, 1);
    checkOutput("ovf_core_reset_fin", core_reset, 1);
    checkOutput("ovf_count", word_count, 4);
    applyStimulus(1'b0, 1'b0, 9'h0, 1'b0);

    // reset mid-load after two accepted words
    pulseStart();
    checkOutput("reload_ovf_cleared", err_overflow, 0);
    applyStimulus(1'b0, 1'b1, 9'h0C1, 1'b0);
    tick();
    in_data = 9'h0C2;
    tick();
    Reset = 1'b1;
    #1;
    checkOutput("mid_rst_wr_en", wr_en, 0);
    checkOutput("mid_rst_core_reset", core_reset, 1);
    checkOutput("mid_rst_count", word_count, 0);
    checkOutput("mid_rst_in_ready", in_ready, 0);
    Reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 9'h0, 1'b0);
    tick();
    pulseStart();
    applyStimulus(1'b0, 1'b1, 9'h0AB, 1'b1);
    tick();
    checkOutput("post_rst_wr_addr", wr_addr, 0);
    checkOutput("post_rst_wr_data", wr_data, 9'h0AB);
    applyStimulus(1'b0, 1'b0, 9'h0, 1'b0);
    tick();
    checkOutput("post_rst_run", core_reset, 0);

`ifdef CYCLE_TIMEOUT_EN
    // first RUN cycle is current; nine more keep RUN, the tenth ends it
    for (int i = 0; i < 9; i++) begin
      tick();
      checkOutput("to_still_run", core_reset, 0);
    end
    tick();
    checkOutput("to_load_done", load_done, 1);
    checkOutput("to_flag", err_timeout, 1);
    pulseStart();
    checkOutput("to_flag_cleared", err_timeout, 0);
    applyStimulus(1'b0, 1'b1, 9'h077, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 9'h0, 1'b0);
    tick();
    for (int i = 0; i < 9; i++) tick();
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    checkOutput("to_done_wins_fin", load_done, 1);
    checkOutput("to_done_wins_flag", err_timeout, 0);
`else
    for (int i = 0; i < 20; i++) tick();
    checkOutput("no_to_still_run", core_reset, 0);
    checkOutput("no_to_flag", err_timeout, 0);
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    checkOutput("no_to_fin", load_done, 1);
    checkOutput("no_to_count", word_count, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Host-side write port for the 9-bit instruction memory.
- Receives machine-code words over a valid/ready stream and writes them to consecutive instruction addresses from 0.
- Holds the core in reset while loading, then releases it and waits for the core's Done.
- Reports completion, word count and error flags to the bench/host.

Parameters:
- IW, 9, instruction word width (matches mach_code).
- AW, 8, instruction address width (matches PC).
- DEPTH, 256, instruction memory depth in words; must satisfy DEPTH <= 2**AW.
- MAX_CYCLES, 4096, RUN-phase cycle limit; used only when CYCLE_TIMEOUT_EN is defined.

Ports:
- Clk  input  1  system clock; all state changes on rising edge.
- Reset  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle pulse that begins a load; honoured only in IDLE or FINISH.
- in_valid  input  1  host word valid.
- in_data  input  IW  host machine-code word.
- in_last  input  1  marks the final word of the program.
- in_ready  output  1  loader can accept a word.
- wr_en  output  1  instruction memory write strobe.
- wr_addr  output  AW  instruction memory write address.
- wr_data  output  IW  instruction memory write data.
- core_reset  output  1  held high to keep the core (ProgCtr etc.) in reset.
- core_done  input  1  core's Done flag.
- load_done  output  1  high in FINISH state.
- word_count  output  AW+1  number of words written in the current or last load.
- err_overflow  output  1  sticky; DEPTH words accepted without in_last.
- err_timeout  output  1  sticky; RUN phase exceeded MAX_CYCLES.

Behaviour:
- Reset values (asynchronous): state=IDLE, core_reset=1; all other outputs 0; internal address counter 0.
- State machine (registered), states IDLE, LOAD, RUN, FINISH.
- IDLE:
  - in_ready=0, core_reset=1.
  - start -> LOAD; clears address counter, word_count, err_overflow, err_timeout.
- LOAD:
  - in_ready=1, core_reset=1.
  - Handshake: a word is accepted only when in_valid && in_ready in the same cycle; in_data and in_last are sampled only then.
  - Write latency is 1 cycle. Next cycle: wr_en=1, wr_addr=current address, wr_data=accepted word. Then the address counter and word_count increment by 1.
  - wr_en is high for exactly one cycle per accepted word; back-to-back acceptance gives back-to-back writes at consecutive addresses.
  - Accepted word with in_last=1 -> in_ready drops the next cycle; state -> RUN in the same cycle as its write.
  - Accepted word at address DEPTH-1 with in_last=0 -> word still written; err_overflow=1; state -> FINISH; core is not released.
  - A one-word program is legal. There is no zero-word load.
- RUN:
  - core_reset=0 from the first RUN cycle; in_ready=0.
  - core_done sampled high -> FINISH next cycle.
  - core_done high in the first RUN cycle is honoured.
- FINISH:
  - load_done=1, core_reset=1, in_ready=0; word_count and error flags hold.
  - start -> LOAD, same clears as from IDLE.
- Other rules:
  - start outside IDLE/FINISH is ignored.
  - in_valid outside LOAD is ignored; nothing is written.
  - Reset asserted mid-LOAD or mid-RUN returns to IDLE immediately with reset values; partial memory contents are left as written.
- Arithmetic:
  - word_count is AW+1 bits so DEPTH=256 is representable.
  - The address counter never wraps; the overflow path stops at DEPTH-1.

Optional Feature:
- Macro: CYCLE_TIMEOUT_EN.
- Defined:
  - A RUN cycle counter clears on entry to RUN and increments each RUN cycle.
  - When it reaches MAX_CYCLES without core_done: err_timeout=1 and state -> FINISH.
  - If core_done and the timeout fall in the same cycle, core_done wins and err_timeout stays 0.
- Not defined: no counter; RUN waits indefinitely; err_timeout is tied to 0.

Decomposition:
- Package loader_pkg: state enum (IDLE, LOAD, RUN, FINISH), IW/AW default constants, DEPTH default.
- Sub-module ldr_cycle_ctr (RUN cycle counter with clear/enable/terminal flag); instantiated only under CYCLE_TIMEOUT_EN.
- Everything else stays in one module.

Test Plan:
- Basic load: start, stream 3 words 0x1A3, 0x055, 0x1FF (last on the 3rd) with in_valid held high -> three consecutive wr_en cycles at addr 0,1,2 with matching data; word_count=3; core_reset falls on the cycle after the 3rd write; core_done=1 -> load_done=1, core_reset=1.
- Backpressure/gaps: in_valid toggles 1,0,1,0,1 with 3 words -> exactly 3 writes at addr 0-2; no write in gap cycles.
- Overflow: DEPTH=4, 4 words all with in_last=0 -> 4 writes at addr 0-3, err_overflow=1, state FINISH; core_reset never drops.
- Reset mid-load: Reset asserted after 2 words accepted -> same cycle: state IDLE, wr_en=0, core_reset=1, word_count=0; a following start loads from addr 0.
- Reload and ignored inputs: start pulses during LOAD and RUN, and in_valid during RUN -> no effect; start in FINISH -> new load from addr 0 with flags cleared.
- Timeout (CYCLE_TIMEOUT_EN, MAX_CYCLES=10): core_done held 0 -> FINISH after 10 RUN cycles, err_timeout=1; repeat with core_done rising on cycle 10 -> err_timeout=0.
